// File: rtl/ring_ctrl.sv
// ring_ctrl: rotary-encoder LED ring controller (position, DOT/BAR pattern, invert, intensity, refresh pulse).
// Define RING_CTRL_LONGPRESS_EN for the short/long-press FSM; otherwise every press just toggles invert.
module ring_ctrl #(
    parameter int          NUM_LEDS    = 12,
    parameter int          WRAP        = 1,
    parameter int          LONG_CYCLES = 20000000,
    parameter logic [7:0]  INT_L0      = 8'd1,
    parameter logic [7:0]  INT_L1      = 8'd2,
    parameter logic [7:0]  INT_L2      = 8'd8,
    parameter logic [7:0]  INT_L3      = 8'd32,
    localparam int         POS_W       = $clog2(NUM_LEDS)
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                rot_up,
    input  logic                rot_dn,
    input  logic                push,
    input  logic [1:0]          intensity_in,
    output logic [NUM_LEDS-1:0] led_mask,
    output logic [7:0]          intensity_out,
    output logic [POS_W+1:0]    state_out,
    output logic                update
);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
    logic [POS_W-1:0]    pos, pos_nxt;
    logic                inverted, inv_nxt, mode, mode_nxt, push_q, rise;
    logic [7:0]          int_nxt;
    logic [NUM_LEDS-1:0] pattern;

    assign rise = push & ~push_q;

    always_comb begin
        pos_nxt = pos;
        if (rot_up && !rot_dn)
            pos_nxt = (pos == POS_MAX) ? ((WRAP != 0) ? '0 : pos) : pos + 1'b1;
        else if (rot_dn && !rot_up)
            pos_nxt = (pos == '0) ? ((WRAP != 0) ? POS_MAX : pos) : pos - 1'b1;
    end

    assign int_nxt = (intensity_in == 2'd0) ? INT_L0 :
                     (intensity_in == 2'd1) ? INT_L1 :
                     (intensity_in == 2'd2) ? INT_L2 : INT_L3;

`ifdef RING_CTRL_LONGPRESS_EN
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
    localparam int CNT_W = $clog2(LONG_CYCLES);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        inv_nxt   = inverted;
        mode_nxt  = mode;
        case (state)
            IDLE: if (rise) begin
                state_nxt = PRESSED;
                cnt_nxt   = '0;
            end
            PRESSED: begin
                cnt_nxt = cnt + 1'b1;
                if (!push) begin
                    inv_nxt   = ~inverted;
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(LONG_CYCLES - 1)) begin
                    mode_nxt  = ~mode;
                    state_nxt = HELD;
                end
            end
            HELD:    if (!push) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
            cnt   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mode  <= mode_nxt;
        end
    end
`else
    assign inv_nxt  = inverted ^ rise;
    assign mode     = 1'b0;
    assign mode_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pos           <= '0;
            inverted      <= 1'b0;
            push_q        <= 1'b1;
            intensity_out <= INT_L0;
            update        <= 1'b0;
        end else begin
            pos           <= pos_nxt;
            inverted      <= inv_nxt;
            push_q        <= push;
            intensity_out <= int_nxt;
            update        <= (pos_nxt != pos) || (inv_nxt != inverted) ||
                             (mode_nxt != mode) || (int_nxt != intensity_out);
        end
    end

    // DOT lights only LED pos; BAR lights LEDs 0..pos
    always_comb begin
        pattern = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            pattern[i] = mode ? (POS_W'(i) <= pos) : (POS_W'(i) == pos);
    end

    assign led_mask  = pattern ^ {NUM_LEDS{inverted}};
    assign state_out = {mode, inverted, pos};
endmodule

// File: tb/tb_ring_ctrl.sv
// tb_ring_ctrl: directed checks of ring_ctrl (wrapping and saturating instances, NUM_LEDS=12, LONG_CYCLES=8).
// Push expectations follow RING_CTRL_LONGPRESS_EN when it is defined for the build.
module tb_ring_ctrl;
    logic        clk = 1'b0;
    logic        res_n, rot_up, rot_dn, rot_up_s, rot_dn_s, push;
    logic [1:0]  intensity_in;
    logic [11:0] led_mask, led_mask_s;
    logic [7:0]  intensity_out, intensity_out_s;
    logic [5:0]  state_out, state_out_s;
    logic        update, update_s;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  int_sel [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
    logic [7:0]  int_exp [4] = '{8'd8, 8'd32, 8'd2, 8'd1};

    always #5 clk = ~clk;

    ring_ctrl #(.NUM_LEDS(12), .WRAP(1), .LONG_CYCLES(8)) u_dut (
        .clk(clk), .res_n(res_n), .rot_up(rot_up), .rot_dn(rot_dn), .push(push),
        .intensity_in(intensity_in), .led_mask(led_mask), .intensity_out(intensity_out),
        .state_out(state_out), .update(update)
    );

    ring_ctrl #(.NUM_LEDS(12), .WRAP(0), .LONG_CYCLES(8)) u_sat (
        .clk(clk), .res_n(res_n), .rot_up(rot_up_s), .rot_dn(rot_dn_s), .push(push),
        .intensity_in(intensity_in), .led_mask(led_mask_s), .intensity_out(intensity_out_s),
        .state_out(state_out_s), .update(update_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        res_n = 1'b0; rot_up = 1'b0; rot_dn = 1'b0; rot_up_s = 1'b0; rot_dn_s = 1'b0;
        push = 1'b0; intensity_in = 2'd0;
        #12;
        check("rst_mask", 32'(led_mask), 32'h001);
        check("rst_state", 32'(state_out), 32'h00);
        check("rst_int", 32'(intensity_out), 32'h01);
        check("rst_upd", 32'(update), 32'h0);
        check("rst_sat_mask", 32'(led_mask_s), 32'h001);
        tick;
        res_n = 1'b1;
        tick;
        check("rel_upd", 32'(update), 32'h0);

        // full clockwise revolution wraps back to LED 0
        for (int i = 1; i <= 12; i++) begin
            rot_up = 1'b1;
            tick;
            rot_up = 1'b0;
            check("t1_pos", 32'(state_out), 32'(i % 12));
            check("t1_mask", 32'(led_mask), 32'(12'h001 << (i % 12)));
            check("t1_upd", 32'(update), 32'h1);
            tick;
            check("t1_upd_lo", 32'(update), 32'h0);
        end
        rot_up = 1'b1; rot_dn = 1'b1;
        tick;
        rot_up = 1'b0; rot_dn = 1'b0;
        check("both_pos", 32'(state_out), 32'h0);
        check("both_upd", 32'(update), 32'h0);
        rot_dn = 1'b1;
        tick;
        rot_dn = 1'b0;
        check("wrapdn_pos", 32'(state_out), 32'd11);
        check("wrapdn_mask", 32'(led_mask), 32'h800);
        check("wrapdn_upd", 32'(update), 32'h1);
        rot_up = 1'b1;
        tick;
        rot_up = 1'b0;
        check("wrapup_mask", 32'(led_mask), 32'h001);

        // saturating instance
        rot_dn_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("sat_lo_pos", 32'(state_out_s), 32'h0);
            check("sat_lo_upd", 32'(update_s), 32'h0);
        end
        rot_up_s = 1'b1;
        tick;
        rot_dn_s = 1'b0;
        check("sat_both_pos", 32'(state_out_s), 32'h0);
        check("sat_both_upd", 32'(update_s), 32'h0);
        for (int i = 0; i < 11; i++) tick;
        check("sat_top_pos", 32'(state_out_s), 32'd11);
        check("sat_top_mask", 32'(led_mask_s), 32'h800);
        check("sat_top_upd", 32'(update_s), 32'h1);
        tick;
        rot_up_s = 1'b0;
        check("sat_hi_pos", 32'(state_out_s), 32'd11);
        check("sat_hi_upd", 32'(update_s), 32'h0);

        for (int k = 0; k < 4; k++) begin
            intensity_in = int_sel[k];
            tick;
            check("int_val", 32'(intensity_out), 32'(int_exp[k]));
            check("int_upd", 32'(update), 32'h1);
            tick;
            check("int_upd_lo", 32'(update), 32'h0);
        end
        check("int_sat", 32'(intensity_out_s), 32'h01);

        // short press inverts the ring
        push = 1'b1;
        tick;
`ifdef RING_CTRL_LONGPRESS_EN
        check("t3_press_mask", 32'(led_mask), 32'h001);
`else
        check("t3_press_mask", 32'(led_mask), 32'hFFE);
        check("t3_press_upd", 32'(update), 32'h1);
`endif
        tick;
        tick;
        push = 1'b0;
        tick;
`ifdef RING_CTRL_LONGPRESS_EN
        check("t3_rel_upd", 32'(update), 32'h1);
`else
        check("t3_rel_upd", 32'(update), 32'h0);
`endif
        check("t3_mask", 32'(led_mask), 32'hFFE);
        check("t3_state", 32'(state_out), 32'h10);
        push = 1'b1;
        tick;
        push = 1'b0;
        tick;
        check("t3_back", 32'(led_mask), 32'h001);
        rot_up = 1'b1;
        tick;
        tick;
        tick;
        rot_up = 1'b0;
        tick;
        check("pos3_mask", 32'(led_mask), 32'h008);

`ifdef RING_CTRL_LONGPRESS_EN
        // long press switches to BAR after LONG_CYCLES
        push = 1'b1;
        for (int k = 0; k < 8; k++) tick;
        check("t4_pre_mask", 32'(led_mask), 32'h008);
        check("t4_pre_upd", 32'(update), 32'h0);
        tick;
        check("t4_mask", 32'(led_mask), 32'h00F);
        check("t4_state", 32'(state_out), 32'h23);
        check("t4_upd", 32'(update), 32'h1);
        tick;
        check("t4_upd_lo", 32'(update), 32'h0);
        push = 1'b0;
        tick;
        check("t4_rel_mask", 32'(led_mask), 32'h00F);
        check("t4_rel_upd", 32'(update), 32'h0);
        push = 1'b1;
        for (int k = 0; k < 8; k++) tick;
        push = 1'b0;
        tick;
        check("t4_edge_mask", 32'(led_mask), 32'hFF0);
        check("t4_edge_state", 32'(state_out), 32'h33);
`else
        // without the FSM a long hold is just one toggle
        push = 1'b1;
        tick;
        check("t6_mask", 32'(led_mask), 32'hFF7);
        check("t6_upd", 32'(update), 32'h1);
        for (int k = 0; k < 19; k++) tick;
        check("t6_hold_upd", 32'(update), 32'h0);
        push = 1'b0;
        tick;
        check("t6_state", 32'(state_out), 32'h13);
        check("t6_rel_upd", 32'(update), 32'h0);
`endif

        // reset mid-press with the button held through release
        push = 1'b1;
        tick;
        tick;
        res_n = 1'b0;
        #1;
        check("t5_rst_mask", 32'(led_mask), 32'h001);
        check("t5_rst_state", 32'(state_out), 32'h00);
        tick;
        res_n = 1'b1;
        for (int k = 0; k < 12; k++) tick;
        check("t5_held_mask", 32'(led_mask), 32'h001);
        check("t5_held_upd", 32'(update), 32'h0);
        push = 1'b0;
        tick;
        check("t5_rel_mask", 32'(led_mask), 32'h001);
        push = 1'b1;
        tick;
        push = 1'b0;
        tick;
        check("t5_repress_mask", 32'(led_mask), 32'hFFE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
